depacketizer_reasm: RTL and testbench

DEPACKETIZER_REASM -- requirements
Module: depacketizer_reasm

---
 rtl/noc_pkg.sv | 21 ++
 rtl/depacketizer_reasm.sv | 115 +++++++++++
 tb/tb_depacketizer_reasm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit header field offsets, payload width helper
// and the reassembly FSM state encoding.
package noc_pkg;

   // Header bit offsets counted down from the flit MSB.
   localparam int FVALID_OFS = 0;
   localparam int HEAD_OFS   = 1;
   localparam int TAIL_OFS   = 2;
   localparam int HDR_BITS   = 3;

   function automatic int payload_width(input int width_pkt, input int addr_w, input int vc_w);
      return width_pkt - HDR_BITS - addr_w - vc_w;
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

endpackage

// File: rtl/depacketizer_reasm.sv
// Reassembles head/body/tail NoC flits into one wide packet and holds it
// until the consumer takes it; protocol violations raise a one-cycle err_out.
module depacketizer_reasm
   import noc_pkg::*;
#(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_PKT        = 36,
   parameter int MAX_FLITS        = 2,
   parameter int WIDTH_DATA       = 56
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH_PKT-1:0]        data_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   output logic [WIDTH_DATA-1:0]       data_out,
   output logic [ADDRESS_WIDTH-1:0]    dst_out,
   output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        err_out
);

   localparam int P      = payload_width(WIDTH_PKT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
   localparam int ASM_W  = MAX_FLITS * P;
   localparam int CW     = $clog2(MAX_FLITS + 1);
   localparam int FV_BIT = WIDTH_PKT - 1 - FVALID_OFS;
   localparam int HD_BIT = WIDTH_PKT - 1 - HEAD_OFS;
   localparam int TL_BIT = WIDTH_PKT - 1 - TAIL_OFS;
   localparam int VC_LSB = WIDTH_PKT - HDR_BITS - VC_ADDRESS_WIDTH;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FLITS);

   state_t                state_reg;
   logic [CW-1:0]         flit_cnt_reg;
   logic [ASM_W-1:0]      asm_reg;

   logic                        f_valid, f_head, f_tail, accept;
   logic [VC_ADDRESS_WIDTH-1:0] f_vc;
   logic [ADDRESS_WIDTH-1:0]    f_dst;
   logic [P-1:0]                f_payload;
   logic [ASM_W-1:0]            head_asm;
   logic [CW-1:0]               cnt_inc;

   assign f_valid   = data_in[FV_BIT];
   assign f_head    = data_in[HD_BIT];
   assign f_tail    = data_in[TL_BIT];
   assign f_vc      = data_in[VC_LSB +: VC_ADDRESS_WIDTH];
   assign f_dst     = data_in[P +: ADDRESS_WIDTH];
   assign f_payload = data_in[P-1:0];

   assign ready_out = (state_reg != FULL);
   assign accept    = valid_in & ready_out & f_valid;
   // A head always starts a fresh assembly: slice 0 loaded, all others zero.
   assign head_asm  = ASM_W'(f_payload) << (ASM_W - P);
   assign cnt_inc   = flit_cnt_reg + 1'b1;
   assign data_out  = asm_reg[ASM_W-1 -: WIDTH_DATA];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         flit_cnt_reg <= '0;
         asm_reg      <= '0;
         dst_out      <= '0;
         vc_out       <= '0;
         valid_out    <= 1'b0;
         err_out      <= 1'b0;
      end else begin
         err_out <= 1'b0;
         case (state_reg)
            IDLE, COLLECT: begin
               if (accept) begin
                  if (f_head) begin
                     asm_reg      <= head_asm;
                     dst_out      <= f_dst;
                     vc_out       <= f_vc;
                     flit_cnt_reg <= CW'(1);
                     // Single-slot configurations overrun on any non-tail head.
                     if (f_tail || MAX_FLITS == 1) begin
                        state_reg <= FULL;
                        valid_out <= 1'b1;
                     end else begin
                        state_reg <= COLLECT;
                     end
                     err_out <= (state_reg == COLLECT) | (!f_tail && MAX_FLITS == 1);
                  end else if (state_reg == IDLE) begin
                     err_out <= 1'b1;
                  end else begin
                     for (int k = 1; k < MAX_FLITS; k++) begin
                        if (flit_cnt_reg == CW'(k))
                           asm_reg[(MAX_FLITS-k)*P-1 -: P] <= f_payload;
                     end
                     flit_cnt_reg <= cnt_inc;
                     if (f_tail || cnt_inc == MAX_CNT) begin
                        state_reg <= FULL;
                        valid_out <= 1'b1;
                        err_out   <= !f_tail;
                     end
                  end
               end
            end
            FULL: begin
               if (ready_in) begin
                  state_reg    <= IDLE;
                  valid_out    <= 1'b0;
                  asm_reg      <= '0;
                  flit_cnt_reg <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_depacketizer_reasm.sv
// Directed bench for depacketizer_reasm at default parameters: single/two-flit
// packets, backpressure, protocol errors, overrun and mid-packet reset.
module tb_depacketizer_reasm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [35:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic [55:0] data_out;
   logic [3:0]  dst_out;
   logic [0:0]  vc_out;
   logic        valid_out;
   logic        ready_in;
   logic        err_out;

   int errors = 0;
   int checks = 0;

   depacketizer_reasm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .dst_out   (dst_out),
      .vc_out    (vc_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .err_out   (err_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge, outputs are checked there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [35:0] flit);
      data_in  = flit;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      data_in  = '0;
   endtask

   task automatic check_pkt(input string tag, input logic v, input logic [55:0] d,
                            input logic [3:0] dst, input logic vc, input logic e);
      check({tag, ".valid"}, 64'(valid_out), 64'(v));
      check({tag, ".data"},  64'(data_out),  64'(d));
      check({tag, ".dst"},   64'(dst_out),   64'(dst));
      check({tag, ".vc"},    64'(vc_out),    64'(vc));
      check({tag, ".err"},   64'(err_out),   64'(e));
   endtask

   initial begin
      rst_n    = 1'b0;
      data_in  = '0;
      valid_in = 1'b0;
      ready_in = 1'b0;
      tick();
      tick();
      check_pkt("reset", 1'b0, 56'h0, 4'h0, 1'b0, 1'b0);
      check("reset.ready_out", 64'(ready_out), 64'd1);
      rst_n = 1'b1;
      tick();

      // Single-flit packet held under backpressure
      send(36'hF5ABCDEF1);
      check_pkt("single", 1'b1, 56'hABCDEF1_0000000, 4'h5, 1'b1, 1'b0);
      check("single.ready_out", 64'(ready_out), 64'd0);
      data_in  = 36'hE7123456F;
      valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_pkt($sformatf("hold%0d", i), 1'b1, 56'hABCDEF1_0000000, 4'h5, 1'b1, 1'b0);
         check($sformatf("hold%0d.ready_out", i), 64'(ready_out), 64'd0);
      end
      valid_in = 1'b0;
      data_in  = '0;
      ready_in = 1'b1;
      tick();
      check_pkt("release", 1'b0, 56'h0, 4'h5, 1'b1, 1'b0);
      check("release.ready_out", 64'(ready_out), 64'd1);

      // Two-flit packet
      send(36'hC31111111);
      check("two.first.valid", 64'(valid_out), 64'd0);
      check("two.first.err", 64'(err_out), 64'd0);
      send(36'hA32222222);
      check_pkt("two", 1'b1, 56'h1111111_2222222, 4'h3, 1'b0, 1'b0);
      tick();
      check("two.drain.valid", 64'(valid_out), 64'd0);

      // Body flit with no packet open
      send(36'hA32222222);
      check("idle_body.err", 64'(err_out), 64'd1);
      check("idle_body.valid", 64'(valid_out), 64'd0);
      tick();
      check("idle_body.err_clear", 64'(err_out), 64'd0);
      check("idle_body.valid_after", 64'(valid_out), 64'd0);

      // New head while collecting: only the second packet comes out
      send(36'hC31111111);
      check("restart.first.err", 64'(err_out), 64'd0);
      send(36'hC74444444);
      check("restart.head.err", 64'(err_out), 64'd1);
      check("restart.head.valid", 64'(valid_out), 64'd0);
      send(36'hA35555555);
      check_pkt("restart", 1'b1, 56'h4444444_5555555, 4'h7, 1'b0, 1'b0);
      tick();
      check("restart.drain.valid", 64'(valid_out), 64'd0);

      // Overrun: two flits without a tail
      send(36'hC31111111);
      send(36'h836666666);
      check_pkt("overrun", 1'b1, 56'h1111111_6666666, 4'h3, 1'b0, 1'b1);
      tick();
      check("overrun.drain.valid", 64'(valid_out), 64'd0);
      check("overrun.drain.err", 64'(err_out), 64'd0);

      // Flit with fvalid=0 is ignored
      send(36'h75ABCDEF1);
      check("nofv.valid", 64'(valid_out), 64'd0);
      check("nofv.err", 64'(err_out), 64'd0);
      check("nofv.ready_out", 64'(ready_out), 64'd1);

      // Reset between head and tail
      send(36'hC31111111);
      rst_n = 1'b0;
      #1;
      check_pkt("midrst", 1'b0, 56'h0, 4'h0, 1'b0, 1'b0);
      check("midrst.ready_out", 64'(ready_out), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      send(36'hA32222222);
      check("midrst.tail.err", 64'(err_out), 64'd1);
      check("midrst.tail.valid", 64'(valid_out), 64'd0);
      tick();
      check("midrst.after.valid", 64'(valid_out), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
